axis_pktframe: RTL and testbench
================================

AXIS_PKTFRAME -- requirements
Module: axis_pktframe

Interface
REQ-001 Parameter DW, default 32: stream data width in bits.
REQ-002 Parameter LGPKT, default 16: width of packet-length and beat counters.
REQ-003 Parameter OPT_HONOR_TLAST, default 1'b1: when set, an upstream TLAST closes the current packet early.
REQ-004 S_AXI_ACLK  in  1  clock; all logic on its rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_en  in  1  framing enable; sampled only at packet boundaries.
REQ-007 i_pkt_len  in  LGPKT  beats per packet; latched at the first beat of each packet; 0 means 2^LGPKT.
REQ-008 S_AXIS_TVALID / S_AXIS_TREADY / S_AXIS_TDATA[DW] / S_AXIS_TLAST  in/out/in/in  input stream from the MM2S DMA.
REQ-009 M_AXIS_TVALID / M_AXIS_TREADY / M_AXIS_TDATA[DW] / M_AXIS_TLAST  out/in/out/out  framed output stream.
REQ-010 o_pkt_count  out  32  count of packets completed on the output (wraps).
REQ-011 o_short  out  1  one-cycle pulse: packet closed early by upstream TLAST.
REQ-012 o_busy  out  1  high while a packet is open or output data is pending.

Function
REQ-013 State machine SHALL have two states: IDLE (no packet open) and ACTIVE (packet open).
- IDLE->ACTIVE on an accepted input beat with i_en=1.
- ACTIVE->IDLE on the accepted input beat that carries the generated TLAST.
REQ-014 In IDLE with i_en=0, S_AXIS_TREADY SHALL be 0.
REQ-015 Deasserting i_en in ACTIVE SHALL NOT stall or truncate the open packet; framing stops only at the next boundary.
REQ-016 On the first beat of a packet:
- remaining SHALL load from i_pkt_len, using 2^LGPKT when i_pkt_len=0.
- remaining is LGPKT+1 bits wide.
REQ-017 Each accepted input beat SHALL decrement remaining by 1.
REQ-018 Generated TLAST = (remaining==1) OR (OPT_HONOR_TLAST AND S_AXIS_TLAST).
REQ-019 When OPT_HONOR_TLAST=0, S_AXIS_TLAST SHALL be ignored.
REQ-020 o_short SHALL pulse for 1 cycle, 1 cycle after accepting a beat whose TLAST came from upstream while remaining>1.
REQ-021 Output buffering: registered output stage plus one-entry skid buffer.
- S_AXIS_TREADY = !skid_valid (and the enable rule of REQ-014).
- Sustained throughput: 1 beat/cycle with M_AXIS_TREADY=1.
- Latency: input accept to M_AXIS_TVALID = 1 cycle.
REQ-022 Beats SHALL NOT be dropped, duplicated or reordered.
- M_AXIS_TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0.
REQ-023 If the output is stalled and one more beat is accepted, that beat SHALL go to the skid buffer.
- S_AXIS_TREADY SHALL drop the next cycle.
- The skid entry SHALL move to the output register on the first M_AXIS_TREADY.
REQ-024 o_pkt_count SHALL increment by 1 on each cycle with M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST; it wraps 0xFFFFFFFF->0.
REQ-025 o_busy = (state==ACTIVE) || M_AXIS_TVALID || skid_valid.

Reset
REQ-026 After i_reset, all of the following SHALL hold:
- state=IDLE; remaining=0.
- M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
- skid_valid=0; o_pkt_count=0; o_short=0; o_busy=0.
- S_AXIS_TREADY = i_en.
REQ-027 i_reset mid-packet SHALL discard the open packet and buffered beats.
- No TLAST is emitted for the discarded packet.
- o_pkt_count SHALL NOT increment for it.

Verification
REQ-028 Basic framing:
- Stimulus: i_pkt_len=4, i_en=1, 12 back-to-back beats, M_AXIS_TREADY=1.
- Response: TLAST on output beats 4, 8 and 12; o_pkt_count=3; one beat per cycle.
REQ-029 Early close:
- Stimulus: i_pkt_len=8, upstream TLAST on beat 3.
- Response: output TLAST on beat 3; o_short pulses once; the next packet restarts with 8 beats.
REQ-030 Backpressure:
- Stimulus: i_pkt_len=5, 10 beats, M_AXIS_TREADY toggling 1,0,0,1.
- Response: the data sequence is intact; S_AXIS_TREADY falls only while the skid is full; TLAST on beats 5 and 10.
REQ-031 Length 0 with a narrow counter:
- Stimulus: LGPKT=4, i_pkt_len=0, 32 beats.
- Response: TLAST on beats 16 and 32; o_pkt_count=2.
REQ-032 Enable dropped mid-packet:
- Stimulus: i_en low at beat 2 of a 6-beat packet.
- Response: beats 3-6 are still accepted; TLAST on beat 6; S_AXIS_TREADY=0 afterwards; o_busy falls once the output drains.
REQ-033 Reset mid-packet:
- Stimulus: i_reset asserted for 1 cycle after beat 3 of 8, with the output stalled.
- Response: the next cycle shows M_AXIS_TVALID=0, o_pkt_count=0, state=IDLE; the next packet frames from beat 1.

Source files
------------

// File: rtl/axis_pktframe.sv
// axis_pktframe: chops an AXI-stream into fixed-length packets.
// Registered output with a one-entry skid; optional early close on TLAST.
module axis_pktframe #(
  parameter int DW              = 32,
  parameter int LGPKT           = 16,
  parameter bit OPT_HONOR_TLAST = 1'b1
) (
  input  logic             S_AXI_ACLK,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [LGPKT-1:0] i_pkt_len,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [DW-1:0]    S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [DW-1:0]    M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic [31:0]      o_pkt_count,
  output logic             o_short,
  output logic             o_busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [LGPKT:0] FULL_LEN =
    {1'b1, {LGPKT{1'b0}}};
  localparam logic [LGPKT:0] ONE =
    {{LGPKT{1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [LGPKT:0]   remaining;
  logic [LGPKT:0]   remaining_nxt;
  logic [LGPKT:0]   len_ext;
  logic [LGPKT:0]   rem_cur;
  logic             accept;
  logic             up_last;
  logic             gen_last;
  logic             early;
  logic             out_free;
  logic             skid_valid;
  logic [DW-1:0]    skid_data;
  logic             skid_last;

  // Input handshake and framing decision for the beat on the bus.
  always_comb begin
    S_AXIS_TREADY = !skid_valid &&
                    ((state == ACTIVE) || i_en);
    accept   = S_AXIS_TVALID && S_AXIS_TREADY;
    len_ext  = (i_pkt_len == '0) ? FULL_LEN
                                 : {1'b0, i_pkt_len};
    rem_cur  = (state == IDLE) ? len_ext : remaining;
    up_last  = OPT_HONOR_TLAST ? S_AXIS_TLAST : 1'b0;
    gen_last = (rem_cur == ONE) || up_last;
    early    = up_last && (rem_cur > ONE);
    out_free = !M_AXIS_TVALID || M_AXIS_TREADY;
    o_busy   = (state == ACTIVE) || M_AXIS_TVALID ||
               skid_valid;
  end

  // Next packet state and beat countdown.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    if (accept) begin
      remaining_nxt = rem_cur - ONE;
      unique case (1'b1)
        gen_last:  state_nxt = IDLE;
        !gen_last: state_nxt = ACTIVE;
      endcase
    end
  end

  // Packet state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Output register refilled from skid first, else from input.
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= skid_data;
        M_AXIS_TLAST  <= skid_last;
        skid_valid    <= 1'b0;
      end else if (accept) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TLAST  <= gen_last;
      end else begin
        M_AXIS_TVALID <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= S_AXIS_TDATA;
      skid_last  <= gen_last;
    end
  end

  // Completed-packet counter and early-close pulse.
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      o_pkt_count <= '0;
      o_short     <= 1'b0;
    end else begin
      if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST)
        o_pkt_count <= o_pkt_count + 32'd1;
      o_short <= accept && early;
    end
  end

endmodule

// File: tb/tb_axis_pktframe.sv
// tb_axis_pktframe: directed checks for axis_pktframe.
// Second instance covers LGPKT=4 with upstream TLAST ignored.
module tb_axis_pktframe;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] pkt_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [31:0] pkt_count;
  logic        s_short;
  logic        busy;

  logic        en_n;
  logic [3:0]  pkt_len_n;
  logic        s_valid_n;
  logic        s_ready_n;
  logic [31:0] s_data_n;
  logic        s_last_n;
  logic        m_valid_n;
  logic        m_ready_n;
  logic [31:0] m_data_n;
  logic        m_last_n;
  logic [31:0] pkt_count_n;
  logic        s_short_n;
  logic        busy_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int occ = 0;
  int shorts = 0;
  int shorts_n = 0;
  int lowcnt = 0;
  bit mon_ready = 0;
  logic [32:0] outq[$];
  logic [32:0] outq_n[$];
  int          stamps[$];

  axis_pktframe u_dut (
    .S_AXI_ACLK    (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_pkt_len     (pkt_len),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TLAST  (s_last),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TLAST  (m_last),
    .o_pkt_count   (pkt_count),
    .o_short       (s_short),
    .o_busy        (busy)
  );

  axis_pktframe #(
    .DW              (32),
    .LGPKT           (4),
    .OPT_HONOR_TLAST (1'b0)
  ) u_n (
    .S_AXI_ACLK    (clk),
    .i_reset       (rst),
    .i_en          (en_n),
    .i_pkt_len     (pkt_len_n),
    .S_AXIS_TVALID (s_valid_n),
    .S_AXIS_TREADY (s_ready_n),
    .S_AXIS_TDATA  (s_data_n),
    .S_AXIS_TLAST  (s_last_n),
    .M_AXIS_TVALID (m_valid_n),
    .M_AXIS_TREADY (m_ready_n),
    .M_AXIS_TDATA  (m_data_n),
    .M_AXIS_TLAST  (m_last_n),
    .o_pkt_count   (pkt_count_n),
    .o_short       (s_short_n),
    .o_busy        (busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Output monitor, fill model and pulse counters.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      occ = 0;
    end else begin
      if (m_valid && m_ready) begin
        outq.push_back({m_last, m_data});
        stamps.push_back(cyc);
      end
      if (s_short) shorts++;
      if (mon_ready) begin
        chk("ready_vs_fill", 64'(s_ready), 64'(occ < 2));
        if (!s_ready) lowcnt++;
      end
      occ = occ + int'(s_valid && s_ready)
                - int'(m_valid && m_ready);
      if (m_valid_n && m_ready_n)
        outq_n.push_back({m_last_n, m_data_n});
      if (s_short_n) shorts_n++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    stamps.delete();
    shorts = 0;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_timeout", 64'(n < 40), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_beats(input string tag,
                           input bit sel,
                           input int n,
                           input logic [31:0] base,
                           input int plen);
    int sz;
    sz = sel ? outq_n.size() : outq.size();
    chk({tag, "_count"}, 64'(sz), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [32:0] got;
      logic [32:0] exp;
      got = 'x;
      if (i < sz) got = sel ? outq_n[i] : outq[i];
      exp = {((i % plen) == plen - 1), base + 32'(i)};
      chk($sformatf("%s_beat%0d", tag, i), 64'(got), 64'(exp));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pkt_len = 16'd4;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1;
    en_n = 1'b0; pkt_len_n = 4'd0;
    s_valid_n = 1'b0; s_data_n = '0; s_last_n = 1'b0;
    m_ready_n = 1'b1;

    // reset state
    do_reset();
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_mlast", 64'(m_last), 64'd0);
    chk("rst_mdata", 64'(m_data), 64'd0);
    chk("rst_count", 64'(pkt_count), 64'd0);
    chk("rst_short", 64'(s_short), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_en1", 64'(s_ready), 64'd1);
    en = 1'b0;
    #1;
    chk("idle_ready_en0", 64'(s_ready), 64'd0);
    en = 1'b1;

    // basic framing, length 4
    @(negedge clk);
    pkt_len = 16'd4;
    for (int i = 0; i < 12; i++)
      send(32'hA000_0000 + 32'(i), 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_beats("basic", 1'b0, 12, 32'hA000_0000, 4);
    chk("basic_pkts", 64'(pkt_count), 64'd3);
    if (stamps.size() == 12)
      chk("basic_rate", 64'(stamps[11] - stamps[0]), 64'd11);
    else
      chk("basic_stamps", 64'(stamps.size()), 64'd12);
    chk("basic_busy", 64'(busy), 64'd0);

    // early close by upstream TLAST
    do_reset();
    pkt_len = 16'd8;
    send(32'hB000_0000, 1'b0);
    send(32'hB000_0001, 1'b0);
    send(32'hB000_0002, 1'b1);
    chk("early_pulse", 64'(s_short), 64'd1);
    for (int i = 3; i < 11; i++)
      send(32'hB000_0000 + 32'(i), 1'b0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("early_count", 64'(outq.size()), 64'd11);
    for (int i = 0; i < 11; i++) begin
      logic [32:0] got;
      got = 'x;
      if (i < outq.size()) got = outq[i];
      chk($sformatf("early_beat%0d", i), 64'(got),
          64'({(i == 2 || i == 10), 32'hB000_0000 + 32'(i)}));
    end
    chk("early_shorts", 64'(shorts), 64'd1);
    chk("early_pkts", 64'(pkt_count), 64'd2);

    // backpressure with skid usage
    do_reset();
    pkt_len   = 16'd5;
    lowcnt    = 0;
    mon_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(32'hC000_0000 + 32'(i), 1'b0);
        s_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 48; k++) begin
          m_ready = (k % 4 == 0) || (k % 4 == 3);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
    join
    mon_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_beats("bp", 1'b0, 10, 32'hC000_0000, 5);
    chk("bp_pkts", 64'(pkt_count), 64'd2);
    chk("bp_skid_used", 64'(lowcnt > 0), 64'd1);

    // LGPKT=4, length 0, upstream TLAST ignored
    en_n      = 1'b1;
    pkt_len_n = 4'd0;
    for (int i = 0; i < 32; i++) begin
      s_valid_n = 1'b1;
      s_data_n  = 32'hD000_0000 + 32'(i);
      s_last_n  = (i == 4);
      #1;
      chk($sformatf("n_ready%0d", i), 64'(s_ready_n), 64'd1);
      @(negedge clk);
    end
    s_valid_n = 1'b0;
    s_last_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk_beats("narrow", 1'b1, 32, 32'hD000_0000, 16);
    chk("narrow_pkts", 64'(pkt_count_n), 64'd2);
    chk("narrow_shorts", 64'(shorts_n), 64'd0);

    // enable dropped mid-packet
    do_reset();
    pkt_len = 16'd6;
    send(32'hE000_0000, 1'b0);
    en = 1'b0;
    for (int i = 1; i < 6; i++)
      send(32'hE000_0000 + 32'(i), 1'b0);
    chk("en_ready_after", 64'(s_ready), 64'd0);
    chk("en_busy_drain", 64'(busy), 64'd1);
    s_data = 32'hE000_0006;
    @(negedge clk);
    chk("en_busy_done", 64'(busy), 64'd0);
    chk("en_ready_hold", 64'(s_ready), 64'd0);
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    chk_beats("en", 1'b0, 6, 32'hE000_0000, 6);
    chk("en_pkts", 64'(pkt_count), 64'd1);

    // reset mid-packet with output stalled
    en = 1'b1;
    pkt_len = 16'd8;
    m_ready = 1'b1;
    send(32'hF000_0000, 1'b0);
    send(32'hF000_0001, 1'b0);
    m_ready = 1'b0;
    send(32'hF000_0002, 1'b0);
    s_valid = 1'b0;
    chk("mid_mvalid_pre", 64'(m_valid), 64'd1);
    chk("mid_skid_full", 64'(s_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    chk("mid_mvalid", 64'(m_valid), 64'd0);
    chk("mid_mlast", 64'(m_last), 64'd0);
    chk("mid_count", 64'(pkt_count), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(32'h1000_0000 + 32'(i), 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_beats("mid", 1'b0, 8, 32'h1000_0000, 8);
    chk("mid_pkts", 64'(pkt_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
